// File: rtl/store_writer.sv
// Store writer: buffers byte/half/word store requests in a small FIFO and
// drains each one to the RAM/UART port one byte per granted cycle.
module store_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,

  input  logic        ena_from_lsb,
  input  logic [31:0] addr_from_lsb,
  input  logic [31:0] data_from_lsb,
  input  logic [2:0]  size_from_lsb,
  output logic        full_to_lsb,
  output logic        done_to_lsb,

  output logic        req_to_arb,
  input  logic        grant_from_arb,

  input  logic        uart_full_from_ram,
  output logic        wr_flag_to_ram,
  output logic [31:0] addr_to_ram,
  output logic [7:0]  data_o_to_ram
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // Request FIFO storage; the size is kept as the index of the last byte.
  logic [31:0]      r_addr_mem [FIFO_DEPTH];
  logic [31:0]      r_data_mem [FIFO_DEPTH];
  logic [1:0]       r_last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // Store currently being drained.
  logic [0:0]       r_state;
  logic [31:0]      r_base;
  logic [31:0]      r_data;
  logic [1:0]       r_last;
  logic [1:0]       r_k;

  logic             r_wr_flag;
  logic [31:0]      r_addr_out;
  logic [7:0]       r_data_out;
  logic             r_done;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_issue;
  logic             w_last_byte;
  logic [1:0]       w_push_last;
  logic [7:0]       w_byte;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Every state change, including FIFO push, is gated by the global ready.
  assign w_push      = rdy & ena_from_lsb & ~w_full;
  assign w_load      = rdy & (r_state == ST_IDLE) & grant_from_arb & ~w_empty;
  assign w_issue     = rdy & (r_state == ST_WRITE) & grant_from_arb & ~uart_full_from_ram;
  assign w_last_byte = w_issue & (r_k == r_last);
  assign w_pop       = w_last_byte;

  // Sizes other than 1 and 2 are handled as full words.
  assign w_push_last = (size_from_lsb == 3'd1) ? 2'd0 :
                       (size_from_lsb == 3'd2) ? 2'd1 : 2'd3;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    w_byte = r_data[7:0];
    case (r_k)
      2'd1:    w_byte = r_data[15:8];
      2'd2:    w_byte = r_data[23:16];
      2'd3:    w_byte = r_data[31:24];
      default: w_byte = r_data[7:0];
    endcase
  end

  // NOTE: storage arrays are not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= addr_from_lsb;
      r_data_mem[r_wptr] <= data_from_lsb;
      r_last_mem[r_wptr] <= w_push_last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_data     <= '0;
      r_last     <= '0;
      r_k        <= '0;
      r_wr_flag  <= 1'b0;
      r_addr_out <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
    end else if (rdy) begin
      // Non-issuing cycles present an idle bus and no completion.
      r_wr_flag  <= 1'b0;
      r_addr_out <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_base  <= r_addr_mem[r_rptr];
            r_data  <= r_data_mem[r_rptr];
            r_last  <= r_last_mem[r_rptr];
            r_k     <= '0;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_issue) begin
            r_wr_flag  <= 1'b1;
            r_addr_out <= r_base + {30'd0, r_k};
            r_data_out <= w_byte;
            if (w_last_byte) begin
              r_done  <= 1'b1;
              r_k     <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_k <= r_k + 2'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign full_to_lsb    = w_full;
  assign req_to_arb     = (r_state == ST_WRITE) | ~w_empty;
  assign done_to_lsb    = r_done;
  assign wr_flag_to_ram = r_wr_flag;
  assign addr_to_ram    = r_addr_out;
  assign data_o_to_ram  = r_data_out;

endmodule

// File: tb/tb_store_writer.sv
// Bench for store_writer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed byte writes.
module tb_store_writer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ena_from_lsb;
  logic [31:0] addr_from_lsb;
  logic [31:0] data_from_lsb;
  logic [2:0]  size_from_lsb;
  logic        full_to_lsb;
  logic        done_to_lsb;
  logic        req_to_arb;
  logic        grant_from_arb;
  logic        uart_full_from_ram;
  logic        wr_flag_to_ram;
  logic [31:0] addr_to_ram;
  logic [7:0]  data_o_to_ram;

  store_writer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .ena_from_lsb       (ena_from_lsb),
    .addr_from_lsb      (addr_from_lsb),
    .data_from_lsb      (data_from_lsb),
    .size_from_lsb      (size_from_lsb),
    .full_to_lsb        (full_to_lsb),
    .done_to_lsb        (done_to_lsb),
    .req_to_arb         (req_to_arb),
    .grant_from_arb     (grant_from_arb),
    .uart_full_from_ram (uart_full_from_ram),
    .wr_flag_to_ram     (wr_flag_to_ram),
    .addr_to_ram        (addr_to_ram),
    .data_o_to_ram      (data_o_to_ram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          n;
  } store_t;

  store_t      fifo_q[$];
  store_t      cur;
  bit          busy = 0;
  int          idx  = 0;
  bit          checking = 0;
  logic        e_wr   = 1'b0;
  logic [31:0] e_addr = '0;
  logic [7:0]  e_data = '0;
  logic        e_done = 1'b0;

  initial forever begin
    @(posedge clk);
    checking = 1;
    if (rst) begin
      fifo_q.delete();
      busy = 0; idx = 0;
      e_wr = 1'b0; e_addr = '0; e_data = '0; e_done = 1'b0;
    end else if (rdy) begin
      logic        push_ok;
      logic [31:0] sh;
      store_t      s;
      push_ok = ena_from_lsb && (fifo_q.size() < DEPTH);
      e_wr = 1'b0; e_addr = '0; e_data = '0; e_done = 1'b0;
      if (!busy) begin
        if (grant_from_arb && fifo_q.size() > 0) begin
          cur = fifo_q[0]; busy = 1; idx = 0;
        end
      end else if (grant_from_arb && !uart_full_from_ram) begin
        sh     = cur.data >> (8 * idx);
        e_wr   = 1'b1;
        e_addr = cur.addr + 32'(idx);
        e_data = sh[7:0];
        idx++;
        if (idx == cur.n) begin
          void'(fifo_q.pop_front());
          busy   = 0;
          e_done = 1'b1;
        end
      end
      if (push_ok) begin
        s.addr = addr_from_lsb;
        s.data = data_from_lsb;
        s.n    = (size_from_lsb == 3'd1) ? 1 : (size_from_lsb == 3'd2) ? 2 : 4;
        fifo_q.push_back(s);
      end
    end
  end

  // Single compare process: every cycle once the first edge has passed.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("wr_flag", 32'(wr_flag_to_ram), 32'(e_wr));
      check("addr",    addr_to_ram,         e_addr);
      check("data",    32'(data_o_to_ram),  32'(e_data));
      check("done",    32'(done_to_lsb),    32'(e_done));
      check("full",    32'(full_to_lsb),    32'(fifo_q.size() == DEPTH));
      check("req",     32'(req_to_arb),     32'(busy || fifo_q.size() > 0));
    end
  end

  // ---------------- write log for literal expectations ----------------
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  wr_t wlog[$];
  int  done_cnt = 0;
  int  cyc = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (wr_flag_to_ram === 1'b1) wlog.push_back('{addr_to_ram, data_o_to_ram, cyc});
    if (done_to_lsb === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_log();
    wlog.delete();
    done_cnt = 0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    ena_from_lsb  = 1'b1;
    addr_from_lsb = a;
    data_from_lsb = d;
    size_from_lsb = s;
    tick();
    ena_from_lsb  = 1'b0;
  endtask

  task automatic check_entry(input string name, input int i, input logic [31:0] a, input logic [7:0] d);
    if (i < wlog.size()) begin
      check({name, "_addr"}, wlog[i].addr, a);
      check({name, "_data"}, 32'(wlog[i].data), 32'(d));
    end else begin
      check({name, "_present"}, 32'(wlog.size()), 32'(i + 1));
    end
  endtask

  logic [31:0] s3_addr [4] = '{32'h200, 32'h210, 32'h220, 32'h230};
  logic [31:0] s3_data [4] = '{32'h000000A1, 32'h0000B2B1, 32'hC4C3C2C1, 32'hD4D3D2D1};
  logic [2:0]  s3_size [4] = '{3'd1, 3'd2, 3'd4, 3'd3};
  logic [31:0] s3_wa   [11] = '{32'h200, 32'h210, 32'h211, 32'h220, 32'h221, 32'h222,
                                32'h223, 32'h230, 32'h231, 32'h232, 32'h233};
  logic [7:0]  s3_wd   [11] = '{8'hA1, 8'hB1, 8'hB2, 8'hC1, 8'hC2, 8'hC3,
                                8'hC4, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
  logic [31:0] s1_wa   [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
  logic [7:0]  s1_wd   [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    rst = 1'b1; rdy = 1'b1; ena_from_lsb = 1'b0;
    addr_from_lsb = '0; data_from_lsb = '0; size_from_lsb = '0;
    grant_from_arb = 1'b0; uart_full_from_ram = 1'b0;
    tick(); tick();
    check("rst_wr",   32'(wr_flag_to_ram), 32'd0);
    check("rst_req",  32'(req_to_arb),     32'd0);
    check("rst_full", 32'(full_to_lsb),    32'd0);
    check("rst_done", 32'(done_to_lsb),    32'd0);
    rst = 1'b0;
    tick();

    // Word store with continuous grant: four consecutive bytes.
    clear_log();
    grant_from_arb = 1'b1;
    push(32'h100, 32'hDDCCBBAA, 3'd4);
    repeat (7) tick();
    check("s1_count", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_entry("s1", i, s1_wa[i], s1_wd[i]);
    if (wlog.size() == 4) check("s1_consecutive", 32'(wlog[3].cyc - wlog[0].cyc), 32'd3);
    check("s1_done", 32'(done_cnt), 32'd1);

    // Single byte held off by UART back-pressure.
    clear_log();
    uart_full_from_ram = 1'b1;
    push(32'h30000, 32'h41, 3'd1);
    repeat (4) tick();
    check("s2_stalled", 32'(wlog.size()), 32'd0);
    uart_full_from_ram = 1'b0;
    repeat (3) tick();
    check("s2_count", 32'(wlog.size()), 32'd1);
    check_entry("s2", 0, 32'h30000, 8'h41);
    check("s2_done", 32'(done_cnt), 32'd1);

    // Fill the FIFO without grant; the fifth request is dropped.
    clear_log();
    grant_from_arb = 1'b0;
    for (int i = 0; i < 4; i++) push(s3_addr[i], s3_data[i], s3_size[i]);
    check("s3_full_after4", 32'(full_to_lsb), 32'd1);
    check("s3_req_waiting", 32'(req_to_arb),  32'd1);
    push(32'h240, 32'hEE, 3'd1);
    check("s3_full_after5", 32'(full_to_lsb), 32'd1);
    grant_from_arb = 1'b1;
    repeat (20) tick();
    check("s3_count", 32'(wlog.size()), 32'd11);
    for (int i = 0; i < 11; i++) check_entry("s3", i, s3_wa[i], s3_wd[i]);
    check("s3_done", 32'(done_cnt), 32'd4);
    check("s3_empty_req", 32'(req_to_arb), 32'd0);

    // Address wrap at the top of the 32-bit space.
    clear_log();
    push(32'hFFFFFFFF, 32'h00001234, 3'd2);
    repeat (5) tick();
    check("s4_count", 32'(wlog.size()), 32'd2);
    check_entry("s4_b0", 0, 32'hFFFFFFFF, 8'h34);
    check_entry("s4_b1", 1, 32'h00000000, 8'h12);

    // Grant withdrawn after byte 1 for two cycles.
    clear_log();
    push(32'h400, 32'h87654321, 3'd4);
    tick(); tick(); tick();
    grant_from_arb = 1'b0;
    tick(); tick();
    check("s5_paused", 32'(wlog.size()), 32'd2);
    grant_from_arb = 1'b1;
    repeat (6) tick();
    check("s5_count", 32'(wlog.size()), 32'd4);
    check_entry("s5_b0", 0, 32'h400, 8'h21);
    check_entry("s5_b1", 1, 32'h401, 8'h43);
    check_entry("s5_b2", 2, 32'h402, 8'h65);
    check_entry("s5_b3", 3, 32'h403, 8'h87);
    check("s5_done", 32'(done_cnt), 32'd1);

    // Reset (with rdy low) after byte 1 of a word store, two more queued.
    clear_log();
    grant_from_arb = 1'b0;
    push(32'h500, 32'h44332211, 3'd4);
    push(32'h600, 32'h55, 3'd1);
    push(32'h700, 32'h66, 3'd1);
    grant_from_arb = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; rdy = 1'b0;
    tick();
    rst = 1'b0; rdy = 1'b1;
    check("s6_wr",   32'(wr_flag_to_ram), 32'd0);
    check("s6_addr", addr_to_ram,         32'd0);
    check("s6_req",  32'(req_to_arb),     32'd0);
    check("s6_full", 32'(full_to_lsb),    32'd0);
    check("s6_done", 32'(done_to_lsb),    32'd0);
    check("s6_partial", 32'(wlog.size()), 32'd2);
    repeat (6) tick();
    check("s6_no_more", 32'(wlog.size()), 32'd2);
    check("s6_no_done", 32'(done_cnt),    32'd0);

    // rdy toggling during a half-word store; the per-cycle model covers it.
    push(32'h800, 32'h0000BEEF, 3'd2);
    for (int i = 0; i < 6; i++) begin
      rdy = ~rdy;
      tick();
    end
    rdy = 1'b1;
    repeat (5) tick();
    check("s7_idle_req", 32'(req_to_arb), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_writer.md
STORE_WRITER -- requirements
Module: store_writer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on posedge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: rdy  in  1  global ready; low freezes all state and holds outputs.
REQ-004 SHALL have ports: ena_from_lsb  in  1  store request valid.
REQ-005 SHALL have ports: addr_from_lsb  in  32  store base address; data_from_lsb  in  32  store data, little-endian.
REQ-006 SHALL have ports: size_from_lsb  in  3  byte count (1, 2 or 4).
REQ-007 SHALL have ports: full_to_lsb  out  1  request FIFO full; done_to_lsb  out  1  one-cycle pulse per completed store.
REQ-008 SHALL have ports: req_to_arb  out  1  bus request; grant_from_arb  in  1  bus granted this cycle.
REQ-009 SHALL have ports: uart_full_from_ram  in  1  RAM/UART back-pressure; wr_flag_to_ram  out  1  1=write, 0=read.
REQ-010 SHALL have ports: addr_to_ram  out  32  byte address; data_o_to_ram  out  8  write byte.
REQ-011 SHALL have parameter FIFO_DEPTH, default 4, number of buffered store requests.

Function
REQ-012 Request FIFO SHALL hold {addr, data, size}; push when ena_from_lsb=1 and full_to_lsb=0; request with full_to_lsb=1 SHALL be dropped (LSB must not issue it).
REQ-013 full_to_lsb SHALL be combinational, 1 iff count==FIFO_DEPTH; same-cycle pop does not clear it for that cycle's push.
REQ-014 Push and pop in the same cycle SHALL leave count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-015 size values other than 1 and 2 SHALL be treated as 4.
REQ-016 FSM states: IDLE, WRITE.
REQ-017 IDLE: req_to_arb=1 iff count>0; on grant_from_arb=1 and count>0, load head, byte index k=0, go WRITE.
REQ-018 WRITE: req_to_arb=1; a byte SHALL issue in a cycle iff grant_from_arb=1, uart_full_from_ram=0, rdy=1.
REQ-019 Issuing byte k SHALL register wr_flag_to_ram=1, addr_to_ram=base+k, data_o_to_ram=data[8k+7:8k], visible next cycle; then k increments.
REQ-020 Cycles with no issue SHALL register wr_flag_to_ram=0, addr_to_ram=0, data_o_to_ram=0; k held.
REQ-021 Issuing byte size-1 SHALL pop the FIFO, pulse done_to_lsb=1 the next cycle, return to IDLE.
REQ-022 Store of size N with continuous grant, no back-pressure SHALL occupy exactly N issue cycles; first write visible 2 cycles after push (1 to FIFO, 1 grant/issue).
REQ-023 Grant loss or uart_full mid-store SHALL pause without restarting; resumes at byte k.
REQ-024 Address arithmetic SHALL be 32-bit, wrapping at 0xFFFFFFFF to 0x00000000.
REQ-025 Stores SHALL complete in FIFO order; no store is reordered or merged.

Reset
REQ-026 rst=1 SHALL: count=0, pointers=0, state=IDLE, k=0, all outputs 0 (wr_flag_to_ram=0, addr_to_ram=0, data_o_to_ram=0, req_to_arb=0, done_to_lsb=0, full_to_lsb=0).
REQ-027 Reset mid-store SHALL abandon the store: remaining bytes not written, no done pulse, queued requests discarded.
REQ-028 rst SHALL take priority over rdy=0.

Verification
REQ-029 Push addr=0x100, data=0xDDCCBBAA, size=4, grant=1 -> writes 0x100:AA, 0x101:BB, 0x102:CC, 0x103:DD on consecutive cycles, one done pulse.
REQ-030 Push size=1 addr=0x30000 data=0x41 with uart_full=1 for 3 cycles -> no write for 3 cycles, then single write 0x30000:41, done.
REQ-031 Five pushes with grant=0 -> full_to_lsb=1 after 4th, 5th dropped; raise grant -> exactly 4 stores written in order, 4 done pulses.
REQ-032 Size=2 at addr=0xFFFFFFFF data=0x1234 -> writes 0xFFFFFFFF:34, 0x00000000:12.
REQ-033 Size=4 store, drop grant after byte 1 for 2 cycles -> bytes 2,3 follow after grant returns, no repeat of bytes 0,1.
REQ-034 Assert rst after byte 1 of a size=4 store with 2 queued -> outputs 0 next cycle, no done, FIFO empty, req_to_arb=0.
